ff_change_monitor: RTL and testbench
====================================

Name: ff_change_monitor

Overview:
- Downstream consumer of the enabled 32-bit register stage (`q` output) used in pause testing.
- Samples `q` every clock and detects value changes.
- Tags each change with a free-running cycle stamp and buffers it in a small FIFO.
- Streams the tagged records to the host-side extern interface over valid/ready, so a bench can confirm no update was lost or duplicated across emulator pause/resume.

Parameters:
- DATA_W, 32, width of the monitored value and of `out_data`.
- STAMP_W, 32, width of the cycle counter and of `out_stamp`.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  stage clock.
- rst_n  input  1  asynchronous, active-low reset.
- q_in  input  DATA_W  value produced by the upstream register stage.
- clear  input  1  synchronous clear of `drop_cnt` and `overflow`.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts the record.
- out_data  output  DATA_W  new value of `q_in` for this record.
- out_stamp  output  STAMP_W  cycle stamp at which the change was sampled.
- drop_cnt  output  DROP_W  number of changes lost to a full FIFO; saturates.
- overflow  output  1  sticky flag: at least one change was dropped.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, async):
  - `prev_q` = 0, which matches the upstream register's reset value, so no record is generated on reset release.
  - stamp counter = 0; FIFO empty.
  - `out_valid` = 0, `out_data` = 0, `out_stamp` = 0, `drop_cnt` = 0, `overflow` = 0, `level` = 0.
- Stamp counter:
  - Increments by 1 every clk edge after reset.
  - Wraps modulo 2^STAMP_W without a flag.
- Change detection:
  - At each edge, if `q_in` != `prev_q`, a push request carries {`q_in`, current stamp}.
  - `prev_q` <= `q_in` every edge, whether or not the push is accepted.
  - One record per distinct transition; a value held steady produces nothing.
- Latency:
  - A change present before edge N is stamped with the counter value at edge N.
  - The record is visible at the output after edge N, i.e. 1 cycle latency into an empty FIFO.
- Output handshake:
  - `out_data`/`out_stamp` show the head entry whenever `out_valid` = 1.
  - Pop occurs at an edge with `out_valid` && `out_ready`.
  - Once asserted, `out_valid` stays high and the head is stable until popped.
- Full FIFO:
  - A push at an edge where level == DEPTH and no pop occurs is dropped.
  - On a drop, `drop_cnt` += 1, saturating at all-ones, and `overflow` <= 1.
- Simultaneous push and pop:
  - Always accepted, including when full; `level` is unchanged.
  - When the FIFO is empty, no bypass: the pushed record appears the next cycle.
- Clear:
  - `clear` = 1 zeroes `drop_cnt` and `overflow` at the edge.
  - If a drop happens in the same cycle, clear wins: the result is 0 / 0.
  - The FIFO is not flushed.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide.
  - Full = MSBs differ and low bits are equal.
  - Empty = pointers equal.
- Reset mid-operation: all contents are discarded immediately; no partial record is emitted after release.

Decomposition:
- Package `ff_mon_pkg`:
  - Record typedef {data, stamp}.
  - Default width constants.
  - Pointer-width helper function.
- Sub-module `ff_mon_fifo`:
  - Generic DEPTH-entry synchronous FIFO with push/pop/full/empty/level.
  - Same clk/rst_n convention.
- Top-level content:
  - Change detector.
  - Stamp counter.
  - Drop/overflow logic.

Test Plan:
- Reset, hold `q_in` = 0 for 10 cycles -> `out_valid` stays 0, `level` = 0, `drop_cnt` = 0.
- Single change:
  - Stimulus: with `out_ready` = 1, drive `q_in` 0 -> 0x0000_00A5 before edge 5.
  - Required: `out_valid` = 1 after edge 5 with `out_data` = 0xA5 and `out_stamp` = 5; popped next edge.
- Back-pressure:
  - Stimulus: `out_ready` = 0, `q_in` steps 1, 2, 3, 4, 5 on consecutive edges.
  - Required: `level` = 4, the value 5 is dropped, `drop_cnt` = 1, `overflow` = 1.
  - Then raise `out_ready`: records 1, 2, 3, 4 drain in order with consecutive stamps.
- Push+pop when full:
  - Stimulus: FIFO full, `out_ready` = 1, and a change to 0xFF arrives in the same cycle.
  - Required: `level` stays 4, `drop_cnt` unchanged, 0xFF is later delivered last.
- Clear/saturation:
  - Stimulus: force 300 drops with DROP_W = 8.
  - Required: `drop_cnt` = 255.
  - Then `clear` coincident with a drop -> `drop_cnt` = 0, `overflow` = 0; FIFO contents intact.
- Async reset:
  - Stimulus: drop `rst_n` mid-cycle while `level` = 3.
  - Required: `out_valid` = 0 and `level` = 0 immediately; stamp restarts at 0.
  - A `q_in` held at 0 after release emits nothing.

Source files
------------

// File: rtl/ff_mon_pkg.sv
`default_nettype none
// ============================================================================
// ff_mon_pkg : shared record type, default widths and pointer-width helper
// Revision   : 1.0
// ============================================================================
package ff_mon_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_STAMP_W = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_DROP_W  = 8;

    // Default-width view of one tagged change record.
    typedef struct packed {
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_STAMP_W-1:0] stamp;
    } mon_rec_t;

    // One extra wrap bit beyond the index lets full and empty be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_mon_fifo.sv
`default_nettype none
// ============================================================================
// ff_mon_fifo : DEPTH-entry synchronous FIFO, registered pointers, no bypass
// Revision    : 1.0
// ============================================================================
module ff_mon_fifo
    import ff_mon_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + DEF_STAMP_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop frees the slot in the same edge, so push while full is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ff_change_monitor.sv
`default_nettype none
// ============================================================================
// ff_change_monitor : stamps each change of q_in and streams it via valid/ready
// Revision          : 1.0
// ============================================================================
module ff_change_monitor
    import ff_mon_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STAMP_W = DEF_STAMP_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DROP_W  = DEF_DROP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        q_in,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [STAMP_W-1:0]       out_stamp,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [STAMP_W-1:0] stamp;
    } rec_t;

    logic [DATA_W-1:0]  prev_q;
    logic [STAMP_W-1:0] stamp;
    rec_t               push_rec;
    rec_t               head_rec;
    logic               change;
    logic               full;
    logic               empty;
    logic               pop;
    logic               drop;

    assign change   = (q_in != prev_q);
    assign push_rec = '{data: q_in, stamp: stamp};
    assign pop      = !empty && out_ready;
    assign drop     = change && full && !pop;

    // prev_q resets to the upstream register's reset value: no spurious record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            stamp  <= '0;
        end else begin
            prev_q <= q_in;
            stamp  <= stamp + STAMP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
            overflow <= 1'b1;
        end
    end

    ff_mon_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (change),
        .push_data (push_rec),
        .pop       (pop),
        .pop_data  (head_rec),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign out_valid = !empty;
    assign out_data  = head_rec.data;
    assign out_stamp = head_rec.stamp;

endmodule
`default_nettype wire

// File: tb/tb_ff_change_monitor.sv
`default_nettype none
// ============================================================================
// tb_ff_change_monitor : queue-model scoreboard plus directed literal checks
// Revision             : 1.0
// ============================================================================
module tb_ff_change_monitor;

    localparam int DATA_W  = 32;
    localparam int STAMP_W = 32;
    localparam int DEPTH   = 4;
    localparam int DROP_W  = 8;
    localparam int SAT     = (1 << DROP_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_W-1:0]     q_in = '0;
    logic                  clear = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic [STAMP_W-1:0]    out_stamp;
    logic [DROP_W-1:0]     drop_cnt;
    logic                  overflow;
    logic [$clog2(DEPTH):0] level;

    int checks = 0;
    int errors = 0;

    ff_change_monitor #(
        .DATA_W (DATA_W), .STAMP_W (STAMP_W), .DEPTH (DEPTH), .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_in      (q_in),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {value, cycle} records, a cycle count, a drop tally.
    typedef struct {
        logic [DATA_W-1:0]  d;
        logic [STAMP_W-1:0] s;
    } rec_t;

    rec_t              mq[$];
    int                m_cyc;
    logic [DATA_W-1:0] m_prev;
    int                m_drops;
    bit                m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cyc   = 0;
            m_prev  = '0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            bit   dropped;
            rec_t r;
            dropped = 1'b0;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (q_in != m_prev) begin
                if (mq.size() < DEPTH) begin
                    r.d = q_in;
                    r.s = STAMP_W'(m_cyc);
                    mq.push_back(r);
                end else begin
                    dropped = 1'b1;
                end
            end
            if (clear) begin
                m_drops = 0;
                m_ovf   = 1'b0;
            end else if (dropped) begin
                m_drops = (m_drops < SAT) ? m_drops + 1 : SAT;
                m_ovf   = 1'b1;
            end
            m_prev = q_in;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("level", 64'(level), 64'(mq.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (mq.size() > 0) begin
                chk("data", 64'(out_data), 64'(mq[0].d));
                chk("stamp", 64'(out_stamp), 64'(mq[0].s));
            end
        end
    end

    initial begin
        // Idle after reset: nothing emitted.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_level", 64'(level), 64'd0);
        chk("idle_drop", 64'(drop_cnt), 64'd0);
        chk("idle_data", 64'(out_data), 64'd0);
        chk("idle_stamp", 64'(out_stamp), 64'd0);

        // Fresh reset so edge numbering restarts at 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        q_in = 32'h0000_00A5;
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_data), 64'hA5);
        chk("single_stamp", 64'(out_stamp), 64'd5);
        @(negedge clk);
        chk("single_popped", 64'(out_valid), 64'd0);

        // Back-pressure: five changes into a four-entry FIFO.
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            q_in = DATA_W'(v);
            @(negedge clk);
        end
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_drop", 64'(drop_cnt), 64'd1);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_head", 64'(out_data), 64'd1);
        chk("bp_stamp", 64'(out_stamp), 64'd7);

        // Push and pop together while full.
        q_in = 32'h0000_00FF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pp_level", 64'(level), 64'd4);
        chk("pp_drop", 64'(drop_cnt), 64'd1);
        chk("pp_head", 64'(out_data), 64'd2);
        chk("pp_stamp", 64'(out_stamp), 64'd8);
        repeat (3) @(negedge clk);
        chk("pp_last", 64'(out_data), 64'hFF);
        chk("pp_last_stamp", 64'(out_stamp), 64'd12);
        @(negedge clk);
        chk("pp_empty", 64'(out_valid), 64'd0);

        // Saturation: 4 accepted then 300 dropped.
        out_ready = 1'b0;
        clear = 1'b1;
        q_in = 32'h100;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 1; i < 304; i++) begin
            q_in = 32'h100 + DATA_W'(i);
            @(negedge clk);
        end
        chk("sat_drop", 64'(drop_cnt), 64'(SAT));
        chk("sat_ovf", 64'(overflow), 64'd1);
        clear = 1'b1;
        q_in = 32'hBEEF;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_level", 64'(level), 64'd4);
        chk("clr_head", 64'(out_data), 64'h100);

        // Asynchronous reset while three entries are held.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ar_level3", 64'(level), 64'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_level", 64'(level), 64'd0);
        chk("ar_data", 64'(out_data), 64'd0);
        @(negedge clk);
        q_in = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_quiet", 64'(out_valid), 64'd0);
        chk("ar_quiet_level", 64'(level), 64'd0);
        q_in = 32'h77;
        @(negedge clk);
        chk("ar_new_data", 64'(out_data), 64'h77);
        chk("ar_new_stamp", 64'(out_stamp), 64'd3);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
